nn_input_framer: RTL and testbench

- Upstream feeder for the one-layer NN top: accepts a serial stream of signed fixed-point samples (valid/ready, last-marked), converts each from IN_WIDTH/IN_NFRAC to WIDTH/NFRAC with round-half-up and saturation, and packs SYS_INPUT_SIZE samples into a parallel frame.
- The frame drives the NN input array. It is held stable until the next complete frame and flagged by a one-cycle out_valid pulse.
- Detects malformed frames (early/late last) and resynchronises without corrupting the held output.

---
 rtl/nn_input_pkg.sv | 51 +++++
 rtl/nn_input_framer_if.sv | 29 ++
 rtl/fx_round_sat.sv | 40 ++++
 rtl/nn_input_framer.sv | 143 ++++++++++++++
 tb/tb_nn_input_framer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_input_pkg.sv
// Shared types and fixed-point helpers for the NN input framer.
// fx_convert is fixed to the default widths so other code can use it as a scalar reference.
package nn_input_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    PUBLISH,
    DISCARD
  } state_t;

  function automatic int sh_of(input int in_nfrac, input int nfrac);
    return in_nfrac - nfrac;
  endfunction

  localparam int DEF_IN_WIDTH = 24;
  localparam int DEF_IN_NFRAC = 12;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NFRAC    = 8;
  localparam int SH           = sh_of(DEF_IN_NFRAC, DEF_NFRAC);

  localparam logic signed [DEF_IN_WIDTH:0] DEF_HALF =
      (SH > 0) ? (DEF_IN_WIDTH+1)'(1 << (SH - 1)) : '0;
  localparam logic signed [DEF_IN_WIDTH:0] DEF_MAX =
      (DEF_IN_WIDTH+1)'((1 << (DEF_WIDTH - 1)) - 1);
  localparam logic signed [DEF_IN_WIDTH:0] DEF_MIN =
      (DEF_IN_WIDTH+1)'(-(1 << (DEF_WIDTH - 1)));

  typedef struct packed {
    logic                        sat;
    logic signed [DEF_WIDTH-1:0] value;
  } fx_result_t;

  function automatic fx_result_t fx_convert(input logic signed [DEF_IN_WIDTH-1:0] in_data);
    logic signed [DEF_IN_WIDTH:0] ext;
    fx_result_t                   res;
    ext = {in_data[DEF_IN_WIDTH-1], in_data};
    ext = ext + DEF_HALF;
    ext = ext >>> SH;
    res.sat   = 1'b0;
    res.value = ext[DEF_WIDTH-1:0];
    if (ext > DEF_MAX) begin
      res.sat   = 1'b1;
      res.value = DEF_MAX[DEF_WIDTH-1:0];
    end else if (ext < DEF_MIN) begin
      res.sat   = 1'b1;
      res.value = DEF_MIN[DEF_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/nn_input_framer_if.sv
// Sample stream in, packed frame and status out, for the NN input framer.
interface nn_input_framer_if #(
  parameter int IN_WIDTH       = 24,
  parameter int WIDTH          = 16,
  parameter int SYS_INPUT_SIZE = 10,
  parameter int CNT_WIDTH      = 16
);
  logic signed [IN_WIDTH-1:0] s_data;
  logic                       s_valid;
  logic                       s_last;
  logic                       s_ready;

  logic signed [WIDTH-1:0]    out_data [0:SYS_INPUT_SIZE-1];
  logic                       out_valid;
  logic                       err_early;
  logic                       err_late;
  logic [CNT_WIDTH-1:0]       frame_count;
  logic [CNT_WIDTH-1:0]       sat_count;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, out_data, out_valid, err_early, err_late, frame_count, sat_count
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, out_data, out_valid, err_early, err_late, frame_count, sat_count
  );
endinterface

// File: rtl/fx_round_sat.sv
// Combinational fixed-point narrowing: round half up, then saturate, with a sat flag.
module fx_round_sat
  import nn_input_pkg::*;
#(
  parameter int IN_WIDTH = 24,
  parameter int IN_NFRAC = 12,
  parameter int WIDTH    = 16,
  parameter int NFRAC    = 8
) (
  input  logic signed [IN_WIDTH-1:0] in_data,
  output logic signed [WIDTH-1:0]    out_data,
  output logic                       sat
);
  localparam int SHIFT = sh_of(IN_NFRAC, NFRAC);

  // One guard bit above the input so adding the half-LSB can never wrap.
  localparam logic signed [IN_WIDTH:0] HALF =
      (SHIFT > 0) ? (IN_WIDTH+1)'(1 << (SHIFT - 1)) : '0;
  localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH:0] MINV = (IN_WIDTH+1)'(-(1 << (WIDTH - 1)));

  logic signed [IN_WIDTH:0] ext;
  logic signed [IN_WIDTH:0] rnd;
  logic signed [IN_WIDTH:0] shf;

  always_comb begin
    ext      = {in_data[IN_WIDTH-1], in_data};
    rnd      = ext + HALF;
    shf      = rnd >>> SHIFT;
    sat      = 1'b0;
    out_data = shf[WIDTH-1:0];
    if (shf > MAXV) begin
      sat      = 1'b1;
      out_data = MAXV[WIDTH-1:0];
    end else if (shf < MINV) begin
      sat      = 1'b1;
      out_data = MINV[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/nn_input_framer.sv
// Converts a serial sample stream to NN fixed point and publishes complete frames in parallel.
// Malformed frames are dropped; the published frame only changes on a good frame.
module nn_input_framer
  import nn_input_pkg::*;
#(
  parameter int IN_WIDTH       = 24,
  parameter int IN_NFRAC       = 12,
  parameter int WIDTH          = 16,
  parameter int NFRAC          = 8,
  parameter int SYS_INPUT_SIZE = 10,
  parameter int CNT_WIDTH      = 16
) (
  input  logic              clk,
  input  logic              rst,
  nn_input_framer_if.slave  bus
);
  localparam int                IDX_W    = $clog2(SYS_INPUT_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SYS_INPUT_SIZE - 1);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        index_reg, index_next;
  logic                    out_valid_reg;
  logic                    err_early_reg, err_early_next;
  logic                    err_late_reg, err_late_next;
  logic [CNT_WIDTH-1:0]    frame_count_reg;
  logic [CNT_WIDTH-1:0]    sat_count_reg;

  logic                    ready;
  logic                    beat;
  logic                    capture;
  logic                    publish;
  logic signed [WIDTH-1:0] conv_data;
  logic                    conv_sat;

  fx_round_sat #(
    .IN_WIDTH (IN_WIDTH),
    .IN_NFRAC (IN_NFRAC),
    .WIDTH    (WIDTH),
    .NFRAC    (NFRAC)
  ) u_conv (
    .in_data  (bus.s_data),
    .out_data (conv_data),
    .sat      (conv_sat)
  );

  assign ready = (state_reg != PUBLISH);
  assign beat  = bus.s_valid && ready;

  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    err_early_next = 1'b0;
    err_late_next  = 1'b0;
    capture        = 1'b0;
    publish        = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (beat) begin
          capture = 1'b1;
          if (index_reg == LAST_IDX) begin
            index_next = '0;
            if (bus.s_last) begin
              state_next = PUBLISH;
            end else begin
              err_late_next = 1'b1;
              state_next    = DISCARD;
            end
          end else if (bus.s_last) begin
            err_early_next = 1'b1;
            index_next     = '0;
          end else begin
            index_next = index_reg + 1'b1;
          end
        end
      end
      PUBLISH: begin
        publish    = 1'b1;
        state_next = COLLECT;
      end
      DISCARD: begin
        // Swallow the rest of an overlong frame up to its s_last.
        if (beat && bus.s_last) begin
          state_next = COLLECT;
          index_next = '0;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= COLLECT;
      index_reg       <= '0;
      out_valid_reg   <= 1'b0;
      err_early_reg   <= 1'b0;
      err_late_reg    <= 1'b0;
      frame_count_reg <= '0;
      sat_count_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      out_valid_reg <= publish;
      err_early_reg <= err_early_next;
      err_late_reg  <= err_late_next;
      if (publish) begin
        frame_count_reg <= frame_count_reg + 1'b1;
      end
      if (capture && conv_sat && (sat_count_reg != {CNT_WIDTH{1'b1}})) begin
        sat_count_reg <= sat_count_reg + 1'b1;
      end
    end
  end

  // Per-lane shadow (filled beat by beat) and published copy (updated only on PUBLISH).
  for (genvar gi = 0; gi < SYS_INPUT_SIZE; gi++) begin : g_lane
    logic signed [WIDTH-1:0] shadow_reg;
    logic signed [WIDTH-1:0] lane_out_reg;

    always_ff @(posedge clk) begin
      if (capture && (index_reg == IDX_W'(gi))) begin
        shadow_reg <= conv_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_out_reg <= '0;
      end else if (publish) begin
        lane_out_reg <= shadow_reg;
      end
    end

    assign bus.out_data[gi] = lane_out_reg;
  end

  assign bus.s_ready     = ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.err_early   = err_early_reg;
  assign bus.err_late    = err_late_reg;
  assign bus.frame_count = frame_count_reg;
  assign bus.sat_count   = sat_count_reg;
endmodule

// File: tb/tb_nn_input_framer.sv
// Directed bench for nn_input_framer: frame-level reference model checked every cycle,
// plus hand-computed expectations for conversion, errors, back-to-back timing and reset.
module tb_nn_input_framer;
  localparam int IN_WIDTH  = 24;
  localparam int IN_NFRAC  = 12;
  localparam int WIDTH     = 16;
  localparam int NFRAC     = 8;
  localparam int SIZE      = 10;
  localparam int CNT_WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nn_input_framer_if #(
    .IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH), .SYS_INPUT_SIZE(SIZE), .CNT_WIDTH(CNT_WIDTH)
  ) bus ();

  nn_input_framer #(
    .IN_WIDTH(IN_WIDTH), .IN_NFRAC(IN_NFRAC), .WIDTH(WIDTH), .NFRAC(NFRAC),
    .SYS_INPUT_SIZE(SIZE), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference conversion in plain integer arithmetic.
  function automatic int model_conv(input logic [IN_WIDTH-1:0] raw, output bit sat);
    longint x, hi, lo;
    int     sh;
    sh = IN_NFRAC - NFRAC;
    x  = longint'($signed(raw));
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -hi - 1;
    if (sh > 0) x = x + (longint'(1) << (sh - 1));
    x   = x >>> sh;
    sat = (x > hi) || (x < lo);
    if (x > hi) x = hi;
    else if (x < lo) x = lo;
    return int'(x);
  endfunction

  // Model state: what each DUT output must read after the latest rising edge.
  bit  started = 0;
  int  cyc = 0;
  bit  m_ready = 1, m_valid = 0, m_early = 0, m_late = 0;
  int  m_frames = 0, m_sat = 0;
  int  m_out [SIZE];
  int  m_buf [$];
  int  m_frame [$];
  bit  m_discard = 0, m_pub_pending = 0;

  initial begin
    int v;
    bit s;
    foreach (m_out[i]) m_out[i] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        started = 1; m_ready = 1; m_valid = 0; m_early = 0; m_late = 0;
        m_frames = 0; m_sat = 0; m_discard = 0; m_pub_pending = 0;
        m_buf.delete();
        foreach (m_out[i]) m_out[i] = 0;
      end else begin
        m_valid = 0; m_early = 0; m_late = 0;
        if (m_pub_pending) begin
          foreach (m_out[i]) m_out[i] = m_frame[i];
          m_valid = 1;
          m_frames = (m_frames + 1) % (1 << CNT_WIDTH);
          m_pub_pending = 0;
          m_ready = 1;
        end else if (bus.s_valid && m_ready) begin
          if (m_discard) begin
            if (bus.s_last) m_discard = 0;
          end else begin
            v = model_conv(bus.s_data, s);
            if (s && m_sat < (1 << CNT_WIDTH) - 1) m_sat++;
            m_buf.push_back(v);
            if (bus.s_last) begin
              if (m_buf.size() == SIZE) begin
                m_frame = m_buf;
                m_pub_pending = 1;
                m_ready = 0;
              end else begin
                m_early = 1;
              end
              m_buf.delete();
            end else if (m_buf.size() == SIZE) begin
              m_late = 1;
              m_discard = 1;
              m_buf.delete();
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  int pulses [$];
  int early_cnt = 0, late_cnt = 0, ready_low = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("s_ready", bus.s_ready, m_ready);
        check("out_valid", bus.out_valid, m_valid);
        check("err_early", bus.err_early, m_early);
        check("err_late", bus.err_late, m_late);
        check("frame_count", bus.frame_count, m_frames);
        check("sat_count", bus.sat_count, m_sat);
        for (int i = 0; i < SIZE; i++)
          check($sformatf("out_data[%0d]", i), longint'($signed(bus.out_data[i])), m_out[i]);
        if (bus.out_valid) begin
          pulses.push_back(cyc);
          $display("[TB] cyc %0d frame published: count=%0d lane0=%04h lane9=%04h sat=%0d",
                   cyc, bus.frame_count, bus.out_data[0], bus.out_data[SIZE-1], bus.sat_count);
        end
        if (bus.err_early) begin
          early_cnt++;
          $display("[TB] cyc %0d early-last frame dropped", cyc);
        end
        if (bus.err_late) begin
          late_cnt++;
          $display("[TB] cyc %0d late-last frame dropped", cyc);
        end
        if (!bus.s_ready) ready_low++;
      end
    end
  end

  logic [IN_WIDTH-1:0] fv [12];

  task automatic send_beat(input logic [IN_WIDTH-1:0] d, input bit l);
    int tries = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (bus.s_ready !== 1'b1 && tries < 8) begin
      tries++;
      @(negedge clk);
    end
    if (tries >= 8) check("s_ready stall timeout", bus.s_ready, 1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      send_beat(fv[i], i == n - 1);
      if (i == gap_at) idle();
    end
  endtask

  task automatic wait_pub();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    if (!bus.out_valid) check("publish timeout", bus.out_valid, 1);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset frame_count", bus.frame_count, 0);
    check("reset sat_count", bus.sat_count, 0);
    check("reset s_ready", bus.s_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset lane0", longint'($signed(bus.out_data[0])), 0);

    // 0x180 = 1.5 * 256 input LSBs -> 0x18 output
    for (int i = 0; i < SIZE; i++) fv[i] = 24'h000180;
    send_frame(SIZE, -1);
    idle();
    wait_pub();
    for (int i = 0; i < SIZE; i++)
      check($sformatf("basic lane%0d", i), longint'($signed(bus.out_data[i])), 24);
    check("basic frame_count", bus.frame_count, 1);

    // Rounding at the half-LSB boundary, with an idle gap mid-frame
    for (int i = 0; i < SIZE; i++) fv[i] = 24'h000000;
    fv[0] = 24'h000008; fv[1] = 24'h000007; fv[2] = 24'hFFFFF8; fv[3] = 24'hFFFFF7;
    send_frame(SIZE, 1);
    idle();
    wait_pub();
    check("round lane0", longint'($signed(bus.out_data[0])), 1);
    check("round lane1", longint'($signed(bus.out_data[1])), 0);
    check("round lane2", longint'($signed(bus.out_data[2])), 0);
    check("round lane3", longint'($signed(bus.out_data[3])), -1);
    check("round sat_count", bus.sat_count, 0);

    // Saturation at both rails
    for (int i = 0; i < SIZE; i++) fv[i] = 24'h000100;
    fv[0] = 24'h7FFFFF; fv[1] = 24'h800000;
    send_frame(SIZE, -1);
    idle();
    wait_pub();
    check("sat lane0", longint'($signed(bus.out_data[0])), 32767);
    check("sat lane1", longint'($signed(bus.out_data[1])), -32768);
    check("sat lane2", longint'($signed(bus.out_data[2])), 16);
    check("sat sat_count", bus.sat_count, 2);
    check("sat frame_count", bus.frame_count, 3);

    // Early last on beat 4, then a clean ramp frame
    for (int i = 0; i < 4; i++) fv[i] = 24'h000200;
    send_frame(4, -1);
    idle();
    repeat (3) @(negedge clk);
    check("early pulse count", early_cnt, 1);
    check("early lane0 held", longint'($signed(bus.out_data[0])), 32767);
    check("early frame_count", bus.frame_count, 3);
    for (int i = 0; i < SIZE; i++) fv[i] = IN_WIDTH'(i * 256);
    send_frame(SIZE, -1);
    idle();
    wait_pub();
    check("ramp lane5", longint'($signed(bus.out_data[5])), 80);
    check("ramp frame_count", bus.frame_count, 4);

    // Late last: 12 beats, last only on the 12th
    for (int i = 0; i < 12; i++) fv[i] = 24'h000300;
    send_frame(12, -1);
    idle();
    repeat (3) @(negedge clk);
    check("late pulse count", late_cnt, 1);
    check("late frame_count", bus.frame_count, 4);
    check("late lane5 held", longint'($signed(bus.out_data[5])), 80);
    for (int i = 0; i < SIZE; i++) fv[i] = 24'hFFFE80;
    send_frame(SIZE, -1);
    idle();
    wait_pub();
    check("post-late lane0", longint'($signed(bus.out_data[0])), -24);
    check("post-late frame_count", bus.frame_count, 5);

    // Back-to-back with s_valid held high, then reset mid third frame
    repeat (2) @(negedge clk);
    pulses.delete();
    ready_low = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < SIZE; i++) fv[i] = IN_WIDTH'((f + 1) * 16 + i * 32);
      send_frame(SIZE, -1);
    end
    for (int i = 0; i < 4; i++) send_beat(24'h000400, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    check("b2b pulse count", pulses.size(), 2);
    if (pulses.size() == 2) check("b2b pulse period", pulses[1] - pulses[0], 11);
    check("b2b ready low cycles", ready_low, 2);
    check("rst frame_count", bus.frame_count, 0);
    check("rst lane0", longint'($signed(bus.out_data[0])), 0);
    check("rst s_ready", bus.s_ready, 1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
